// File: rtl/packet_pkg.sv
// Shared packet geometry, header field positions and the ingress shaper state type.
package packet_pkg;
  localparam int PACKET_WIDTH = 16;
  localparam int DEPTH        = 4;
  localparam int SRC_LSB      = 0;
  localparam int TGT_LSB      = 4;
  localparam int FIELD_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } shaper_state_e;
endpackage

// File: rtl/ingress_queue.sv
// Circular FIFO with wrap-bit pointers; flush empties it in one edge,
// but a pop in the same cycle is still taken as the entry being issued.
module ingress_queue #(
  parameter int W      = 16,
  parameter int QDEPTH = 4,
  localparam int AW    = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [QDEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A push into a full queue is fine when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (flush)       rd_ptr <= do_push ? wr_ptr + ONE : wr_ptr;
      else if (do_pop) rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/port_ingress_shaper.sv
// Ingress shaper for one switch port: header screen, local queue, and an issue
// rule that keeps one FIFO slot of margin for a write still in flight.
module port_ingress_shaper
  import packet_pkg::*;
#(
  parameter int PORT_ID        = 0,
  parameter int QDEPTH         = 4,
  parameter int ALLOW_LOOPBACK = 0,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PACKET_WIDTH-1:0] in_pkt,
  input  logic                    flush,
  input  logic                    sw_full,
  input  logic                    sw_afull,
  output logic                    sw_valid_in,
  output logic [PACKET_WIDTH-1:0] sw_pkt,
  output logic [CNT_W-1:0]        acc_cnt,
  output logic [CNT_W-1:0]        bad_cnt,
  output logic [CNT_W-1:0]        flush_cnt,
  output shaper_state_e           state
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  // Handshake: a packet transfers on any cycle with in_valid && in_ready;
  // in_ready never depends on in_valid, and in_pkt need only be stable then.
  logic [FIELD_W-1:0]      src;
  logic [FIELD_W-1:0]      tgt;
  logic                    legal;
  logic                    accept;
  logic                    push;
  logic                    bad;
  logic                    issue_ok;
  logic [PACKET_WIDTH-1:0] q_head;
  logic [AW:0]             q_count;
  logic                    q_full;
  logic                    q_empty;
  logic [AW:0]             flush_amt;
  logic [AW:0]             count_next;
  shaper_state_e           state_next;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [AW:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign src = in_pkt[SRC_LSB +: FIELD_W];
  assign tgt = in_pkt[TGT_LSB +: FIELD_W];

  always_comb begin
    legal = (tgt != '0) && (src == FIELD_W'(PORT_ID));
    if (ALLOW_LOOPBACK == 0 && tgt[PORT_ID]) legal = 1'b0;
  end

  assign in_ready = !rst && !flush && !q_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign bad      = accept && !legal;
  // Our own write of last cycle may not be counted in sw_full yet, so demand afull=0.
  assign issue_ok = !q_empty && (sw_valid_in ? !sw_afull : !sw_full);

  assign flush_amt  = q_count - (issue_ok ? ONE : '0);
  assign count_next = q_count + (push ? ONE : '0) - (issue_ok ? ONE : '0);

  ingress_queue #(.W(PACKET_WIDTH), .QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_pkt),
    .pop       (issue_ok),
    .flush     (flush),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_next = state;
    if (flush || count_next == '0) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:          state_next = ISSUE;
        ISSUE, STALL:  state_next = issue_ok ? ISSUE : STALL;
        default:       state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sw_valid_in <= 1'b0;
      sw_pkt      <= '0;
      acc_cnt     <= '0;
      bad_cnt     <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_next;
      sw_valid_in <= issue_ok;
      if (issue_ok) begin
        sw_pkt  <= q_head;
        acc_cnt <= sat_add(acc_cnt, ONE);
      end
      if (bad)   bad_cnt   <= sat_add(bad_cnt, ONE);
      if (flush) flush_cnt <= sat_add(flush_cnt, flush_amt);
    end
  end
endmodule

// File: tb/tb_port_ingress_shaper.sv
// Directed bench for port_ingress_shaper (PORT_ID=1), with a 2-bit counter twin for saturation.
module tb_port_ingress_shaper;
  import packet_pkg::*;

  localparam int PID = 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic [PACKET_WIDTH-1:0] in_pkt = '0;
  logic                    flush = 1'b0;
  logic                    sw_full = 1'b0;
  logic                    sw_afull = 1'b0;
  logic                    in_ready;
  logic                    sw_valid_in;
  logic [PACKET_WIDTH-1:0] sw_pkt;
  logic [15:0]             acc_cnt, bad_cnt, flush_cnt;
  shaper_state_e           state;
  logic                    s_in_ready, s_sw_valid_in;
  logic [PACKET_WIDTH-1:0] s_sw_pkt;
  logic [1:0]              s_acc_cnt, s_bad_cnt, s_flush_cnt;
  shaper_state_e           s_state;

  int n_cmp = 0;
  int n_fail = 0;
  int n_issued = 0;
  logic [PACKET_WIDTH-1:0] exp_q[$];

  port_ingress_shaper #(.PORT_ID(PID), .QDEPTH(4), .ALLOW_LOOPBACK(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .flush(flush), .sw_full(sw_full), .sw_afull(sw_afull), .sw_valid_in(sw_valid_in),
    .sw_pkt(sw_pkt), .acc_cnt(acc_cnt), .bad_cnt(bad_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  port_ingress_shaper #(.PORT_ID(PID), .QDEPTH(4), .ALLOW_LOOPBACK(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_pkt(in_pkt),
    .flush(flush), .sw_full(sw_full), .sw_afull(sw_afull), .sw_valid_in(s_sw_valid_in),
    .sw_pkt(s_sw_pkt), .acc_cnt(s_acc_cnt), .bad_cnt(s_bad_cnt), .flush_cnt(s_flush_cnt), .state(s_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic                    v;
    logic [PACKET_WIDTH-1:0] pkt;
    logic                    rdy;
    logic                    ov;
    logic [PACKET_WIDTH-1:0] opkt;
    int                      acc;
    int                      bad;
  } vec_t;

  vec_t vt[12];

  function automatic logic legal(input logic [PACKET_WIDTH-1:0] p);
    logic [3:0] s;
    logic [3:0] t;
    s = p[3:0];
    t = p[7:4];
    return (t != 4'd0) && (s == 4'(PID)) && !t[PID];
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and score any packet written to the port.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sw_valid_in === 1'b1) begin
      n_issued++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_issue: got pkt 0x%0h, want no write", sw_pkt);
      end else begin
        logic [PACKET_WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (sw_pkt !== e) begin
          n_fail++;
          $display("FAIL sb_pkt_order: got 0x%0h, want 0x%0h", sw_pkt, e);
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [PACKET_WIDTH-1:0] p, input logic f,
                       input logic af, input logic fl, input logic chk, input logic exp_rdy);
    @(negedge clk);
    in_valid = v;
    in_pkt   = p;
    sw_full  = f;
    sw_afull = af;
    flush    = fl;
    #1;
    if (chk) check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (v && exp_rdy && legal(p)) exp_q.push_back(p);
    tick();
  endtask

  initial begin
    vt[0]  = '{1'b1, 16'h0151, 1'b1, 1'b0, 16'h0000, 0, 0};
    vt[1]  = '{1'b1, 16'h0251, 1'b1, 1'b1, 16'h0151, 1, 0};
    vt[2]  = '{1'b1, 16'h0351, 1'b1, 1'b1, 16'h0251, 2, 0};
    vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0351, 3, 0};
    vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0351, 3, 0};
    vt[5]  = '{1'b1, 16'h0401, 1'b1, 1'b0, 16'h0351, 3, 1};
    vt[6]  = '{1'b1, 16'h0552, 1'b1, 1'b0, 16'h0351, 3, 2};
    vt[7]  = '{1'b1, 16'h0621, 1'b1, 1'b0, 16'h0351, 3, 3};
    vt[8]  = '{1'b1, 16'h0701, 1'b1, 1'b0, 16'h0351, 3, 4};
    vt[9]  = '{1'b1, 16'h08D1, 1'b1, 1'b0, 16'h0351, 3, 4};
    vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h08D1, 4, 4};
    vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h08D1, 4, 4};

    // reset state
    @(negedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("rst_sw_valid", {31'd0, sw_valid_in}, 32'd0);
    check("rst_sw_pkt", {16'd0, sw_pkt}, 32'd0);
    check("rst_acc", {16'd0, acc_cnt}, 32'd0);
    check("rst_bad", {16'd0, bad_cnt}, 32'd0);
    check("rst_flush", {16'd0, flush_cnt}, 32'd0);
    check("rst_state", {30'd0, state}, {30'd0, IDLE});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // back-to-back issue and header screen
    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].v, vt[i].pkt, 1'b0, 1'b0, 1'b0, 1'b1, vt[i].rdy);
      check($sformatf("vec%0d_sw_valid", i), {31'd0, sw_valid_in}, {31'd0, vt[i].ov});
      check($sformatf("vec%0d_sw_pkt", i), {16'd0, sw_pkt}, {16'd0, vt[i].opkt});
      check($sformatf("vec%0d_acc", i), {16'd0, acc_cnt}, vt[i].acc);
      check($sformatf("vec%0d_bad", i), {16'd0, bad_cnt}, vt[i].bad);
      check($sformatf("vec%0d_sat_acc", i), {30'd0, s_acc_cnt}, sat3(vt[i].acc));
      check($sformatf("vec%0d_sat_bad", i), {30'd0, s_bad_cnt}, sat3(vt[i].bad));
    end

    // queue fills behind a full port, then drains in order
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h1051 + 16'(i << 8), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("full_hold_sw_valid", {31'd0, sw_valid_in}, 32'd0);
    end
    cycle(1'b1, 16'h1451, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("full_state_stall", {30'd0, state}, {30'd0, STALL});
    n_issued = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 4) check("drain_b2b_valid", {31'd0, sw_valid_in}, 32'd1);
    end
    check("drain_issued", n_issued, 4);
    check("drain_sb_left", exp_q.size(), 0);
    check("drain_acc", {16'd0, acc_cnt}, 32'd8);
    check("drain_sat_acc", {30'd0, s_acc_cnt}, 32'd3);

    // almost-full port: never two writes back to back
    cycle(1'b1, 16'h2051, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h2151, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n_issued = 0;
    begin
      logic prev;
      prev = 1'b0;
      for (int i = 0; i < 6; i++) begin
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("afull_no_b2b", {31'd0, prev & sw_valid_in}, 32'd0);
        prev = sw_valid_in;
      end
    end
    check("afull_issued", n_issued, 2);
    check("afull_acc", {16'd0, acc_cnt}, 32'd10);

    // flush of 3 queued entries behind a full port
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h3051 + 16'(i << 8), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h3351, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
    check("flush_state", {30'd0, state}, {30'd0, IDLE});
    check("flush_cnt", {16'd0, flush_cnt}, 32'd3);
    check("flush_sw_valid", {31'd0, sw_valid_in}, 32'd0);
    check("flush_sat_cnt", {30'd0, s_flush_cnt}, 32'd3);
    n_issued = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_nothing_after", n_issued, 0);

    // flush coinciding with an issue: head goes out, the rest are dropped
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h5051 + 16'(i << 8), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n_issued = 0;
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
    check("flush_issue_valid", {31'd0, sw_valid_in}, 32'd1);
    check("flush_issue_pkt", {16'd0, sw_pkt}, 32'h5051);
    check("flush_issue_cnt", {16'd0, flush_cnt}, 32'd5);
    check("flush_issue_acc", {16'd0, acc_cnt}, 32'd11);
    check("flush_issue_state", {30'd0, state}, {30'd0, IDLE});
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("flush_issue_total", n_issued, 1);

    // reset with 2 queued and a write in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h6051 + 16'(i << 8), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, sw_valid_in}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    exp_q.delete();
    check("mid_rst_valid", {31'd0, sw_valid_in}, 32'd0);
    check("mid_rst_pkt", {16'd0, sw_pkt}, 32'd0);
    check("mid_rst_acc", {16'd0, acc_cnt}, 32'd0);
    check("mid_rst_bad", {16'd0, bad_cnt}, 32'd0);
    check("mid_rst_flush", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_issued = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_rst_no_issue", n_issued, 0);
    cycle(1'b1, 16'h7051, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_rst_issue_valid", {31'd0, sw_valid_in}, 32'd1);
    check("post_rst_acc", {16'd0, acc_cnt}, 32'd1);
    check("post_rst_issued", n_issued, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
